// File: rtl/arith_sequencer.sv
// Sequences ADD/SUB/MUL/DIV over one shared external 8-bit adder-subtractor.
// ADD/SUB and divide-by-zero finish in 2 cycles, MUL and DIV in 9; a start while busy is dropped.
module arith_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         opcode,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               flag,
  output logic               as_op,
  output logic [WIDTH-1:0]   as_a,
  output logic [WIDTH-1:0]   as_b,
  input  logic [WIDTH-1:0]   as_s,
  input  logic               as_c
);

  typedef enum logic [2:0] {IDLE, ADDSUB, MUL, DIV, DONE} state_t;

  state_t             state;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   hi;   // MUL: upper product half, DIV: partial remainder
  logic [WIDTH-1:0]   lo;   // MUL: multiplier shifting out, DIV: dividend/quotient
  logic [2:0]         cnt;

  logic               div_zero;
  logic               accept;
  logic [WIDTH-1:0]   r_shift;
  logic [WIDTH-1:0]   r_next;
  logic [WIDTH-1:0]   q_next;
  logic [2*WIDTH-1:0] mul_next;

  assign div_zero = (b_q == '0);
  assign r_shift  = {hi[WIDTH-2:0], lo[WIDTH-1]};
  // A set remainder MSB means the shifted value exceeds any 8-bit divisor.
  assign accept   = hi[WIDTH-1] | as_c;
  assign r_next   = accept ? as_s : r_shift;
  assign q_next   = {lo[WIDTH-2:0], accept};
  assign mul_next = {as_c, as_s, lo[WIDTH-1:1]};

  always_comb begin
    as_op = 1'b0;
    as_a  = '0;
    as_b  = '0;
    case (state)
      ADDSUB: begin
        as_op = op_q[0];
        as_a  = a_q;
        as_b  = b_q;
      end
      MUL: begin
        as_a = hi;
        as_b = lo[0] ? a_q : '0;
      end
      DIV: begin
        if (!div_zero) begin
          as_op = 1'b1;
          as_a  = r_shift;
          as_b  = b_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      flag   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (start) begin
            op_q <= opcode;
            a_q  <= a_in;
            b_q  <= b_in;
            cnt  <= '0;
            busy <= 1'b1;
            hi   <= '0;
            if (!opcode[1]) begin
              state <= ADDSUB;
            end else if (!opcode[0]) begin
              state <= MUL;
              lo    <= b_in;
            end else begin
              state <= DIV;
              lo    <= a_in;
            end
          end
        end
        ADDSUB: begin
          result <= {{WIDTH{1'b0}}, as_s};
          flag   <= op_q[0] ? ~as_c : as_c;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end
        MUL: begin
          {hi, lo} <= mul_next;
          cnt      <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            result <= mul_next;
            flag   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DIV: begin
          if (div_zero) begin
            result <= {a_q, {WIDTH{1'b1}}};
            flag   <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            hi  <= r_next;
            lo  <= q_next;
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              result <= {r_next, q_next};
              flag   <= 1'b0;
              busy   <= 1'b0;
              done   <= 1'b1;
              state  <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arith_sequencer.sv
// Bench for arith_sequencer: arithmetic reference model plus directed operations.
module tb_arith_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  opcode;
  logic [7:0]  a_in;
  logic [7:0]  b_in;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        flag;
  logic        as_op;
  logic [7:0]  as_a;
  logic [7:0]  as_b;
  logic [7:0]  as_s;
  logic        as_c;

  int checks = 0;
  int errors = 0;

  arith_sequencer #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .result(result), .flag(flag),
    .as_op(as_op), .as_a(as_a), .as_b(as_b), .as_s(as_s), .as_c(as_c)
  );

  // External adder-subtractor: subtract is A + ~B + 1, C is the raw carry-out.
  logic [8:0] adder_sum;
  always_comb begin
    adder_sum = as_op ? ({1'b0, as_a} + {1'b0, ~as_b} + 9'd1) : ({1'b0, as_a} + {1'b0, as_b});
    as_s = adder_sum[7:0];
    as_c = adder_sum[8];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outcome from plain arithmetic, timing from the documented latencies.
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [15:0] m_res = '0;
  logic        m_flag = 1'b0;
  logic [15:0] pend_res = '0;
  logic        pend_flag = 1'b0;
  int          m_left = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_res = '0; m_flag = 1'b0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1; m_busy = 1'b0; m_res = pend_res; m_flag = pend_flag;
        end
      end else if (start) begin
        m_busy = 1'b1;
        case (opcode)
          2'b00: begin
            pend_res = 16'(({8'h00, a_in} + {8'h00, b_in}) & 16'h00FF);
            pend_flag = (int'(a_in) + int'(b_in)) > 255;
            m_left = 1;
          end
          2'b01: begin
            pend_res = {8'h00, 8'(a_in - b_in)};
            pend_flag = a_in < b_in;
            m_left = 1;
          end
          2'b10: begin
            pend_res = 16'(int'(a_in) * int'(b_in));
            pend_flag = 1'b0;
            m_left = 8;
          end
          default: begin
            if (b_in == 0) begin
              pend_res = {a_in, 8'hFF}; pend_flag = 1'b1; m_left = 1;
            end else begin
              pend_res = {8'(a_in % b_in), 8'(a_in / b_in)}; pend_flag = 1'b0; m_left = 8;
            end
          end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("result", result, m_res);
    chk("flag", flag, m_flag);
    if (!m_busy) chk("as_idle", {as_op, as_a, as_b}, 17'h0);
  end

  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    start = 1'b1; opcode = op; a_in = a; b_in = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int cyc0, input logic [15:0] exp_res,
                           input logic exp_flag, input int exp_lat);
    int cyc;
    bit seen;
    cyc = cyc0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) seen = 1'b1;
    end
    if (!seen) chk({name, "_timeout"}, 0, 1);
    else begin
      chk({name, "_lat"}, cyc, exp_lat);
      chk({name, "_res"}, result, exp_res);
      chk({name, "_flag"}, flag, exp_flag);
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [15:0] exp_res, input logic exp_flag,
                        input int exp_lat);
    @(posedge clk); #1;
    issue(op, a, b);
    wait_done(name, 0, exp_res, exp_flag, exp_lat);
  endtask

  initial begin
    int dones;
    rst = 1'b1; start = 1'b0; opcode = 2'b00; a_in = '0; b_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_as", {as_op, as_a, as_b}, 0);
    rst = 1'b0;

    run_op("add_200_100", 2'b00, 8'd200, 8'd100, 16'h002C, 1'b1, 2);
    run_op("sub_5_7",     2'b01, 8'd5,   8'd7,   16'h00FE, 1'b1, 2);
    run_op("sub_7_5",     2'b01, 8'd7,   8'd5,   16'h0002, 1'b0, 2);
    run_op("mul_255_255", 2'b10, 8'd255, 8'd255, 16'hFE01, 1'b0, 9);
    run_op("mul_13_11",   2'b10, 8'd13,  8'd11,  16'h008F, 1'b0, 9);
    run_op("div_200_7",   2'b11, 8'd200, 8'd7,   16'h041C, 1'b0, 9);
    run_op("div_255_1",   2'b11, 8'd255, 8'd1,   16'h00FF, 1'b0, 9);
    run_op("div_9_0",     2'b11, 8'd9,   8'd0,   16'h09FF, 1'b1, 2);
    run_op("mul_0_77",    2'b10, 8'd0,   8'd77,  16'h0000, 1'b0, 9);
    run_op("div_5_9",     2'b11, 8'd5,   8'd9,   16'h0500, 1'b0, 9);

    // Start while DONE is showing: accepted immediately.
    issue(2'b00, 8'd1, 8'd2);
    wait_done("b2b_add", 0, 16'h0003, 1'b0, 2);
    issue(2'b10, 8'd6, 8'd7);
    wait_done("b2b_mul", 0, 16'h002A, 1'b0, 9);

    // Start pulse in the middle of a MUL must be dropped.
    @(posedge clk); #1;
    issue(2'b10, 8'd13, 8'd11);
    repeat (3) @(negedge clk);
    start = 1'b1; opcode = 2'b00; a_in = 8'd1; b_in = 8'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done("mul_ignore", 4, 16'h008F, 1'b0, 9);

    // Reset during MUL cycle 4 aborts without a done pulse.
    @(posedge clk); #1;
    issue(2'b10, 8'd255, 8'd255);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_result", result, 0);
    chk("abort_flag", flag, 0);
    rst = 1'b0;
    dones = 0;
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    chk("abort_no_done", dones, 0);
    run_op("after_abort", 2'b11, 8'd100, 8'd10, 16'h000A, 1'b0, 9);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
